// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path: frame FSM states,
// frame layout constants and the odd-parity check.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam int   DATA_BITS   = 8;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // A frame is good when the data bits plus the parity bit hold an odd number of ones
    function automatic logic oddParityOk(input logic [DATA_BITS-1:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Show-ahead synchronous FIFO: the head entry is always presented on popData_o,
// and a pop advances the head at the next clock edge. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module ps2_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           pushData_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           popData_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [CW-1:0]    count_q;
    logic             doPush;
    logic             doPop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_COUNT);
    assign doPop   = pop_i & ~empty_o;
    assign doPush  = push_i & (~full_o | doPop);

    assign count_o   = count_q;
    assign popData_o = empty_o ? '0 : mem_q[rdPtr_q];

    // Storage array; contents need no reset because the count gates visibility
    always_ff @(posedge clk) begin
        if (!rst && doPush) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronises and deglitches the PS/2 pins,
// decodes 11-bit frames, checks start/parity/stop and buffers good bytes in a
// show-ahead FIFO with sticky error flags for the IO side.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ps2_clk,
    input  logic                              ps2_dat,
    input  logic                              rd_en,
    output logic [7:0]                        rd_data,
    output logic                              rd_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              rx_pulse,
    output logic                              parity_err,
    output logic                              frame_err,
    output logic                              overflow,
    input  logic                              err_clr
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]    FILT_LAST    = 4'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES);
    localparam logic [2:0]    LAST_BIT     = 3'(DATA_BITS - 1);

    logic [1:0]    clkSync_q;
    logic [1:0]    datSync_q;
    logic          syncClk;
    logic          syncDat;

    logic [3:0]    filtCnt_q;
    logic          filtClk_q;
    logic          filtPrev_q;
    logic          fallEdge;

    ps2_state_e    state_q, state_d;
    logic [2:0]    bitIdx_q, bitIdx_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] timeout_q, timeout_d;

    logic          pushReq;
    logic          setParity;
    logic          setFrame;
    logic          fifoPop;
    logic          fifoFull;
    logic          fifoEmpty;
    logic          pushDrop;

    logic          rxPulse_q;
    logic          parityErr_q;
    logic          frameErr_q;
    logic          overflow_q;

    assign syncClk  = clkSync_q[1];
    assign syncDat  = datSync_q[1];
    assign fallEdge = filtPrev_q & ~filtClk_q;

    // Two-flop synchronisers for both asynchronous pins, idling high like the bus
    always_ff @(posedge clk) begin
        if (rst) begin
            clkSync_q <= 2'b11;
            datSync_q <= 2'b11;
        end else begin
            clkSync_q <= {clkSync_q[0], ps2_clk};
            datSync_q <= {datSync_q[0], ps2_dat};
        end
    end

    // Filtered clock follows the synchronised clock only after FILTER_LEN stable cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            filtCnt_q  <= '0;
            filtClk_q  <= 1'b1;
            filtPrev_q <= 1'b1;
        end else begin
            filtPrev_q <= filtClk_q;
            if (syncClk == filtClk_q) begin
                filtCnt_q <= '0;
            end else if (filtCnt_q == FILT_LAST) begin
                filtClk_q <= syncClk;
                filtCnt_q <= '0;
            end else begin
                filtCnt_q <= filtCnt_q + 4'd1;
            end
        end
    end

    // Frame FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bitIdx_q  <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            timeout_q <= '0;
        end else begin
            state_q   <= state_d;
            bitIdx_q  <= bitIdx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            timeout_q <= timeout_d;
        end
    end

    // Frame FSM: one step per filtered falling edge, with a stalled-clock abort
    always_comb begin
        state_d   = state_q;
        bitIdx_d  = bitIdx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        pushReq   = 1'b0;
        setParity = 1'b0;
        setFrame  = 1'b0;

        if (state_q == IDLE || fallEdge) begin
            timeout_d = '0;
        end else begin
            timeout_d = timeout_q + 1'b1;
        end

        if (state_q != IDLE && timeout_q == TIMEOUT_LAST) begin
            state_d   = IDLE;
            timeout_d = '0;
            setFrame  = 1'b1;
        end else if (fallEdge) begin
            case (state_q)
                IDLE: begin
                    if (syncDat == START_LEVEL) begin
                        state_d  = DATA;
                        bitIdx_d = '0;
                    end
                end
                DATA: begin
                    shift_d  = {syncDat, shift_q[7:1]};
                    bitIdx_d = bitIdx_q + 3'd1;
                    if (bitIdx_q == LAST_BIT) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    parity_d = syncDat;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (syncDat != STOP_LEVEL) begin
                        setFrame = 1'b1;
                    end else if (!oddParityOk(shift_q, parity_q)) begin
                        setParity = 1'b1;
                    end else begin
                        pushReq = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign fifoPop  = rd_en & ~fifoEmpty;
    assign pushDrop = pushReq & fifoFull & ~fifoPop;

    ps2_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (pushReq),
        .pushData_i (shift_q),
        .pop_i      (rd_en),
        .popData_o  (rd_data),
        .count_o    (fifo_count),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty)
    );

    // Receive strobe and sticky error flags; a set event beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            rxPulse_q   <= 1'b0;
            parityErr_q <= 1'b0;
            frameErr_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            rxPulse_q <= pushReq & ~pushDrop;
            if (setParity) begin
                parityErr_q <= 1'b1;
            end else if (err_clr) begin
                parityErr_q <= 1'b0;
            end
            if (setFrame) begin
                frameErr_q <= 1'b1;
            end else if (err_clr) begin
                frameErr_q <= 1'b0;
            end
            if (pushDrop) begin
                overflow_q <= 1'b1;
            end else if (err_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign rd_valid   = ~fifoEmpty;
    assign rx_pulse   = rxPulse_q;
    assign parity_err = parityErr_q;
    assign frame_err  = frameErr_q;
    assign overflow   = overflow_q;

endmodule
